// File: rtl/multicycle_control.sv
// Control FSM for a multicycle RV32 subset datapath (R-type, OP-IMM, load, store, branch).
// Memory handshakes are bounded by a wait counter. A timeout or an illegal instruction
// parks the controller in TRAP until reset.
module multicycle_control #(
  parameter int ALUCTL_W      = 4,
  parameter int SUPPORT_ITYPE = 1,
  parameter int TIMEOUT       = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         inst,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                instr_done,
  output logic                trap,
  output logic [2:0]          state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NONE, C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH
  } class_e;

  state_e           state_q;
  class_e           cls_q, cls_d;
  logic [3:0]       alu_q, alu_d;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_expired;
  logic             inst_unused;

  // The decoder looks only at the opcode, funct3 and inst[30].
  assign inst_unused = ^{inst[31], inst[29:15], inst[11:7]};
  assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));

  // Decode the instruction class and ALU code; C_NONE marks an illegal encoding.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    cls_d = C_NONE;
    alu_d = 4'b0000;
    case (inst[6:0])
      7'b0110011: begin
        cls_d = C_RTYPE;
        case ({inst[30], inst[14:12]})
          4'b0000: alu_d = 4'b0010;
          4'b1000: alu_d = 4'b0110;
          4'b0111: alu_d = 4'b0000;
          4'b0110: alu_d = 4'b0001;
          default: cls_d = C_NONE;
        endcase
      end
      7'b0010011: begin
        if (SUPPORT_ITYPE != 0) begin
          cls_d = C_ITYPE;
          case (inst[14:12])
            3'b000:  alu_d = 4'b0010;
            3'b111:  alu_d = 4'b0000;
            3'b110:  alu_d = 4'b0001;
            default: cls_d = C_NONE;
          endcase
        end
      end
      7'b0000011: begin cls_d = C_LOAD;   alu_d = 4'b0010; end
      7'b0100011: begin cls_d = C_STORE;  alu_d = 4'b0010; end
      7'b1100011: begin cls_d = C_BRANCH; alu_d = 4'b0110; end
      default:    ;
    endcase
  end

  // State register, latched decode and the handshake wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NONE;
      alu_q   <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so the later
      // assignments below override this default within the same edge.
      cnt_q <= '0;
      case (state_q)
        S_FETCH: begin
          if (imem_ack)         state_q <= S_DECODE;
          else if (cnt_expired) state_q <= S_TRAP;
          else                  cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_DECODE: begin
          cls_q   <= cls_d;
          alu_q   <= alu_d;
          state_q <= (cls_d == C_NONE) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (cls_q)
            C_RTYPE, C_ITYPE: state_q <= S_WB;
            C_LOAD, C_STORE:  state_q <= S_MEM;
            C_BRANCH:         state_q <= S_FETCH;
            default:          state_q <= S_TRAP;
          endcase
        end
        S_MEM: begin
          if (dmem_ack)         state_q <= (cls_q == C_LOAD) ? S_WB : S_FETCH;
          else if (cnt_expired) state_q <= S_TRAP;
          else                  cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_WB:    state_q <= S_FETCH;
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Datapath controls decoded from the current state. Reset gates the fetch
  // outputs because the state register already reads FETCH while reset is held.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = '0;
    instr_done = 1'b0;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = reset;
        IRWrite  = reset & imem_ack;
      end
      S_EXEC: begin
        ALUControl = ALUCTL_W'(alu_q);
        ALUSrc     = (cls_q == C_ITYPE) || (cls_q == C_LOAD) || (cls_q == C_STORE);
        if (cls_q == C_BRANCH) begin
          Branch     = 1'b1;
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req   = 1'b1;
        ALUSrc     = 1'b1;
        ALUControl = ALUCTL_W'(4'b0010);
        MemRead    = (cls_q == C_LOAD);
        MemWrite   = (cls_q == C_STORE);
        if (dmem_ack && (cls_q == C_STORE)) begin
          PCWrite    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = (cls_q == C_LOAD);
        PCWrite    = 1'b1;
        instr_done = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. Each instruction is turned into
// an expected cycle-by-cycle trace from its class and the chosen ack delays. The DUT is
// compared against that trace on every falling edge.
module tb_multicycle_control;

  localparam int TO = 6;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   inst;
  logic          imem_ack, dmem_ack;
  logic          imem_req, dmem_req, IRWrite, PCWrite, Branch, MemRead, MemWrite;
  logic          MemtoReg, ALUSrc, RegWrite, instr_done, trap;
  logic [AW-1:0] ALUControl;
  logic [2:0]    state;

  multicycle_control #(.ALUCTL_W(AW), .SUPPORT_ITYPE(1), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .instr_done(instr_done), .trap(trap), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          imem_req, dmem_req, irw, pcw, br, mr, mw, m2r, alusrc, rw;
    logic [AW-1:0] alu;
    logic          done, trap;
  } obs_t;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_BAD} kind_e;

  int n_checks = 0;
  int n_errors = 0;
  bit trapped  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o.st = state;          o.imem_req = imem_req; o.dmem_req = dmem_req;
    o.irw = IRWrite;       o.pcw = PCWrite;       o.br = Branch;
    o.mr = MemRead;        o.mw = MemWrite;       o.m2r = MemtoReg;
    o.alusrc = ALUSrc;     o.rw = RegWrite;       o.alu = ALUControl;
    o.done = instr_done;   o.trap = trap;
    return o;
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Instruction classes and ALU codes from the ISA subset tables.
  function automatic void ref_decode(input logic [31:0] ins, output kind_e k, output logic [3:0] alu);
    logic [3:0] p;
    p   = {ins[30], ins[14:12]};
    k   = K_BAD;
    alu = 4'h0;
    case (ins[6:0])
      7'h33: case (p)
               4'h0: begin k = K_R; alu = 4'h2; end
               4'h8: begin k = K_R; alu = 4'h6; end
               4'h7: begin k = K_R; alu = 4'h0; end
               4'h6: begin k = K_R; alu = 4'h1; end
               default: ;
             endcase
      7'h13: case (ins[14:12])
               3'h0: begin k = K_I; alu = 4'h2; end
               3'h7: begin k = K_I; alu = 4'h0; end
               3'h6: begin k = K_I; alu = 4'h1; end
               default: ;
             endcase
      7'h03: begin k = K_LD; alu = 4'h2; end
      7'h23: begin k = K_ST; alu = 4'h2; end
      7'h63: begin k = K_BR; alu = 4'h6; end
      default: ;
    endcase
  endfunction

  // One clock cycle: drive acks just after the rising edge, compare on the falling edge.
  task automatic cyc(input string tag, input logic ia, input logic da, input obs_t e);
    imem_ack = ia;
    dmem_ack = da;
    @(negedge clk);
    check(tag, {12'b0, observe()}, {12'b0, e});
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic do_reset();
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    #1 reset = 1'b0;
    #1 check("rst_async", {12'b0, observe()}, {12'b0, blank(3'd0)});
    @(negedge clk);
    check("rst_hold", {12'b0, observe()}, {12'b0, blank(3'd0)});
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Delay d <= TO means an ack arrives after d idle cycles; d > TO means no ack (timeout).
  task automatic do_instr(input logic [31:0] ins, input int fd, input int md, input bit abort);
    kind_e      k;
    logic [3:0] alu;
    obs_t       e;
    ref_decode(ins, k, alu);
    for (int i = 0; i <= TO && i <= fd; i++) begin
      e = blank(3'd0);
      e.imem_req = 1'b1;
      if (i == fd) begin
        inst  = ins;
        e.irw = 1'b1;
        cyc("fetch_ack", 1'b1, rb(), e);
      end else begin
        inst = $urandom();
        cyc("fetch_wait", 1'b0, rb(), e);
      end
    end
    if (fd > TO) begin trapped = 1'b1; return; end

    cyc("decode", rb(), rb(), blank(3'd1));
    if (k == K_BAD) begin trapped = 1'b1; return; end

    e        = blank(3'd2);
    e.alu    = AW'(alu);
    e.alusrc = (k == K_I) || (k == K_LD) || (k == K_ST);
    if (k == K_BR) begin e.br = 1'b1; e.pcw = 1'b1; e.done = 1'b1; end
    cyc("exec", rb(), rb(), e);
    if (k == K_BR) return;

    if (k == K_LD || k == K_ST) begin
      for (int i = 0; i <= TO && i <= md; i++) begin
        e          = blank(3'd3);
        e.dmem_req = 1'b1;
        e.alusrc   = 1'b1;
        e.alu      = AW'(4'h2);
        e.mr       = (k == K_LD);
        e.mw       = (k == K_ST);
        if (abort && i == 1) begin
          imem_ack = rb();
          dmem_ack = 1'b0;
          #2 check("mem_pre_rst", {12'b0, observe()}, {12'b0, e});
          do_reset();
          return;
        end
        if (i == md) begin
          e.pcw  = (k == K_ST);
          e.done = (k == K_ST);
          cyc("mem_ack", rb(), 1'b1, e);
        end else begin
          cyc("mem_wait", rb(), 1'b0, e);
        end
      end
      if (md > TO) begin trapped = 1'b1; return; end
      if (k == K_ST) return;
    end

    e      = blank(3'd4);
    e.rw   = 1'b1;
    e.m2r  = (k == K_LD);
    e.pcw  = 1'b1;
    e.done = 1'b1;
    cyc("wb", rb(), rb(), e);
  endtask

  // Run one instruction; if it trapped, confirm TRAP is absorbing, then reset.
  task automatic run(input logic [31:0] ins, input int fd, input int md, input bit abort);
    obs_t e;
    do_instr(ins, fd, md, abort);
    if (trapped) begin
      e      = blank(3'd5);
      e.trap = 1'b1;
      for (int i = 0; i < 4; i++) begin
        inst = $urandom();
        cyc("trap", rb(), rb(), e);
      end
      do_reset();
      trapped = 1'b0;
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 99);
    if (r < 80) return $urandom_range(0, 2);
    if (r < 93) return TO;
    return TO + 1 + $urandom_range(0, 2);
  endfunction

  logic [3:0] legal_p [4] = '{4'h0, 4'h8, 4'h7, 4'h6};

  initial begin
    logic [31:0] ins;
    logic [3:0]  p;
    reset    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    inst     = '0;
    #2 check("reset_state", {12'b0, observe()}, {12'b0, blank(3'd0)});
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    run(32'h002081B3, 0, 0, 1'b0);       // add
    run(32'h402081B3, 0, 0, 1'b0);       // sub
    run(32'h0000A183, 0, 3, 1'b0);       // lw, dmem_ack after 3 waits
    run(32'h0020A023, 0, 0, 1'b0);       // sw
    run(32'h00208063, 0, 0, 1'b0);       // beq
    run(32'h0000007F, 0, 0, 1'b0);       // illegal opcode
    run(32'h00209013, 1, 0, 1'b0);       // OP-IMM funct3 001, illegal
    run(32'h002081B3, TO + 1, 0, 1'b0);  // fetch timeout
    run(32'h002081B3, TO, 0, 1'b0);      // ack on the final fetch cycle
    run(32'h0000A183, 1, TO, 1'b0);      // ack on the final MEM cycle
    run(32'h0000A183, 0, TO + 1, 1'b0);  // MEM timeout
    run(32'h0020A023, 0, 4, 1'b1);       // reset during a MEM wait
    run(32'h00100093, 0, 0, 1'b0);       // addi right after the abort

    for (int n = 0; n < 300; n++) begin
      ins = $urandom();
      case ($urandom_range(0, 11))
        0, 1, 2: begin
          ins[6:0] = 7'h33;
          if ($urandom_range(0, 3) != 0) begin
            p          = legal_p[$urandom_range(0, 3)];
            ins[30]    = p[3];
            ins[14:12] = p[2:0];
          end
        end
        3, 4:    ins[6:0] = 7'h13;
        5, 6:    ins[6:0] = 7'h03;
        7, 8:    ins[6:0] = 7'h23;
        9, 10:   ins[6:0] = 7'h63;
        default: ;
      endcase
      run(ins, pick_delay(), pick_delay(), ($urandom_range(0, 29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be: ALUCTL_W, default 4, ALUControl width (at least 4); SUPPORT_ITYPE, default 1, enables OP-IMM decode; TIMEOUT, default 15, number of cycles to wait for an ack before trapping (at least 1).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 inst  in  32  instruction; valid in the cycle imem_ack=1 and held stable by the datapath IR afterwards.
REQ-005 imem_ack, dmem_ack  in  1 each  memory completion strobes.
REQ-006 imem_req, dmem_req  out  1 each  memory requests.
REQ-007 IRWrite, PCWrite  out  1 each  IR load and PC update strobes.
REQ-008 Branch, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite  out  1 each  datapath controls.
REQ-009 ALUControl  out  ALUCTL_W  ALU operation, zero-extended 4-bit code.
REQ-010 instr_done, trap  out  1 each  retire pulse and sticky error flag.
REQ-011 state  out  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Function
REQ-012 The FSM SHALL be FETCH -> DECODE -> EXEC -> {MEM, WB, FETCH}; MEM -> {WB, FETCH}; WB -> FETCH; any state -> TRAP on error; TRAP is absorbing.
REQ-013 FETCH: imem_req=1; IRWrite=imem_ack, combinational from the ack; on imem_ack go to DECODE.
REQ-014 DECODE SHALL latch the class and ALU code from inst with p={inst[30],inst[14:12]}, then go to EXEC, or to TRAP if the instruction is illegal.
REQ-015 R-type (0110011) SHALL decode p=0000 to 0010 (add), 1000 to 0110 (sub), 0111 to 0000 (and) and 0110 to 0001 (or); any other p is illegal.
REQ-016 OP-IMM (0010011), when SUPPORT_ITYPE=1, SHALL decode funct3 000 to 0010, 111 to 0000 and 110 to 0001; any other funct3 is illegal, and the whole opcode is illegal when SUPPORT_ITYPE=0.
REQ-017 Load (0000011) and store (0100011) SHALL decode to ALU code 0010; branch (1100011) SHALL decode to 0110; every other opcode is illegal.
REQ-018 EXEC: ALUControl=latched code; ALUSrc=1 for OP-IMM, load and store. R-type and OP-IMM go to WB; load and store go to MEM; branch asserts Branch=1, PCWrite=1 and instr_done=1, then goes to FETCH.
REQ-019 MEM: dmem_req=1, ALUSrc=1 and ALUControl=0010, held every cycle until the ack; MemRead=1 for load, MemWrite=1 for store.
REQ-020 On dmem_ack a load SHALL go to WB; a store SHALL pulse PCWrite and instr_done and go to FETCH.
REQ-021 WB: RegWrite=1, MemtoReg=1 only for load, PCWrite=1 and instr_done=1 for exactly one cycle, then go to FETCH.
REQ-022 Every control not asserted in the current state SHALL be driven 0; no output ever carries x. ALUControl=0 outside EXEC and MEM.
REQ-023 A wait counter of width $clog2(TIMEOUT+1) SHALL clear on entry to FETCH or MEM and increment each cycle those states wait without an ack.
REQ-024 When the wait counter reaches TIMEOUT with no ack in that cycle, the FSM SHALL go to TRAP; an ack in the same cycle wins.
REQ-025 TRAP: trap=1 and all other outputs 0 until reset; acks SHALL be ignored.
REQ-026 Stray acks: imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-027 Latency with zero-wait acks SHALL be: R-type/OP-IMM 4 cycles, load 5, store 4, branch 3, each counted from FETCH entry to the next FETCH entry.

Reset
REQ-028 While reset=0: state=FETCH, wait counter 0, latched decode 0, trap=0, and all outputs 0 except imem_req, which is 0 during reset and 1 in the first cycle after release.
REQ-029 Reset asserted mid-instruction, including during MEM with dmem_req=1, SHALL abort immediately and asynchronously; no PCWrite or RegWrite is issued for the aborted instruction.

Verification
REQ-030 inst=0x002081B3 (add) with immediate acks -> states 0,1,2,4; ALUControl=0010 in EXEC; RegWrite=1, PCWrite=1 and instr_done=1 in WB only.
REQ-031 inst=0x402081B3 (sub), then 0x0000A183 (lw) with dmem_ack delayed 3 cycles -> ALUControl 0110, then 0010; MemRead held for 4 MEM cycles; WB has MemtoReg=1.
REQ-032 inst=0x0020A023 (sw), then 0x00208063 (beq) -> MemWrite=1 with RegWrite=0 and store done after MEM; Branch=1 with ALUControl=0110 in EXEC, then FETCH.
REQ-033 inst=0x0000007F, or 0x00209013 with SUPPORT_ITYPE=1 (funct3 001) -> TRAP after DECODE; trap stays 1 under random acks until reset.
REQ-034 imem_ack withheld -> TRAP entered exactly TIMEOUT+1 cycles after FETCH entry; with the ack arriving on that same final cycle -> DECODE instead of TRAP.
REQ-035 reset pulsed low during a MEM wait -> state=0 asynchronously, all strobes 0, and normal fetch resumes after release.
